// File: rtl/pc_call_stack.sv
// 16-bit program counter with a LIFO return-address stack (jump, step, call, return).
// Optional macro PC_STACK_CHECK_EN: suppress stack overflow/underflow and raise sticky err.
module pc_call_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    input  logic             call,
    input  logic             ret,
    output logic [WIDTH-1:0] out,
    output logic [PTR_W:0]   count,
    output logic             empty,
    output logic             full,
    output logic             err
);

    localparam logic [PTR_W:0]   COUNT_MAX = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   COUNT_ONE = 1;
    localparam logic [PTR_W-1:0] WP_ONE    = 1;
    localparam logic [WIDTH-1:0] PC_ONE    = 1;

    logic [WIDTH-1:0] stackMem [DEPTH];

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [PTR_W-1:0] wp_q;
    logic [PTR_W-1:0] wp_d;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             pushEn;
    logic [WIDTH-1:0] pcPlusOne;
    logic [WIDTH-1:0] stackTop;
    logic [PTR_W-1:0] wpMinusOne;
    logic             stackEmpty;
    logic             stackFull;
`ifdef PC_STACK_CHECK_EN
    logic             err_q;
    logic             err_d;
`endif

    assign pcPlusOne  = pc_q + PC_ONE;
    assign wpMinusOne = wp_q - WP_ONE;
    assign stackTop   = stackMem[wpMinusOne];
    assign stackEmpty = (count_q == '0);
    assign stackFull  = (count_q == COUNT_MAX);

    // One action per edge, priority ret > call > load > inc > hold.
    always_comb begin
        pc_d    = pc_q;
        wp_d    = wp_q;
        count_d = count_q;
        pushEn  = 1'b0;
`ifdef PC_STACK_CHECK_EN
        err_d   = err_q;
`endif
        if (ret) begin
            if (stackEmpty) begin
`ifdef PC_STACK_CHECK_EN
                err_d = 1'b1;
`else
                pc_d  = '0;
`endif
            end else begin
                pc_d    = stackTop;
                wp_d    = wpMinusOne;
                count_d = count_q - COUNT_ONE;
            end
        end else if (call) begin
            if (stackFull) begin
`ifdef PC_STACK_CHECK_EN
                err_d  = 1'b1;
`else
                // Circular overwrite of the oldest entry; count saturates at DEPTH.
                pushEn = 1'b1;
                wp_d   = wp_q + WP_ONE;
                pc_d   = in;
`endif
            end else begin
                pushEn  = 1'b1;
                wp_d    = wp_q + WP_ONE;
                count_d = count_q + COUNT_ONE;
                pc_d    = in;
            end
        end else if (load) begin
            pc_d = in;
        end else if (inc) begin
            pc_d = pcPlusOne;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q    <= '0;
            wp_q    <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            wp_q    <= wp_d;
            count_q <= count_d;
        end
    end

    // Stack RAM has no reset; a push during reset is discarded.
    always_ff @(posedge clock) begin
        if (!reset && pushEn) begin
            stackMem[wp_q] <= pcPlusOne;
        end
    end

`ifdef PC_STACK_CHECK_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign out   = pc_q;
    assign count = count_q;
    assign empty = stackEmpty;
    assign full  = stackFull;

endmodule

// File: tb/tb_pc_call_stack.sv
// Self-checking bench for pc_call_stack: constant vector table plus a queue-based
// stack model for the overflow/underflow sequences; results go through a scoreboard.
module tb_pc_call_stack;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] in;
    logic        load;
    logic        inc;
    logic        call;
    logic        ret;
    logic [15:0] out;
    logic [3:0]  count;
    logic        empty;
    logic        full;
    logic        err;

    pc_call_stack #(.WIDTH(16), .DEPTH(8), .PTR_W(3)) dut (
        .clock (clock),
        .reset (reset),
        .in    (in),
        .load  (load),
        .inc   (inc),
        .call  (call),
        .ret   (ret),
        .out   (out),
        .count (count),
        .empty (empty),
        .full  (full),
        .err   (err)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        rst;
        logic [15:0] din;
        logic        ld;
        logic        ic;
        logic        cl;
        logic        rt;
        logic [15:0] eOut;
        logic [3:0]  eCnt;
    } vec_t;

    typedef struct {
        string       name;
        logic [15:0] eOut;
        logic [3:0]  eCnt;
        logic        eErr;
    } exp_t;

    vec_t vecs[$];
    exp_t expQ[$];
    int   checkCount = 0;
    int   passCount  = 0;

    // Independent reference: a SystemVerilog queue used as a bounded LIFO.
    logic [15:0] mPc;
    logic [15:0] mStack[$];
    logic        mErr;

    function automatic vec_t mk(string nm, logic r, logic [15:0] d, logic ld, logic ic,
                                logic cl, logic rt, logic [15:0] eo, logic [3:0] ec);
        vec_t v;
        v.name = nm; v.rst = r; v.din = d; v.ld = ld; v.ic = ic; v.cl = cl; v.rt = rt;
        v.eOut = eo; v.eCnt = ec;
        return v;
    endfunction

    task automatic checkField(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic checkOutput();
        exp_t e;
        if (expQ.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL scoreboard: got an output, expected queue empty");
        end else begin
            e = expQ.pop_front();
            checkField({e.name, " out"},   32'(out),   32'(e.eOut));
            checkField({e.name, " count"}, 32'(count), 32'(e.eCnt));
            checkField({e.name, " empty"}, 32'(empty), 32'(e.eCnt == 4'd0));
            checkField({e.name, " full"},  32'(full),  32'(e.eCnt == 4'd8));
            checkField({e.name, " err"},   32'(err),   32'(e.eErr));
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [15:0] d, input logic ld,
                                 input logic ic, input logic cl, input logic rt, input exp_t e);
        reset = r; in = d; load = ld; inc = ic; call = cl; ret = rt;
        expQ.push_back(e);
        @(posedge clock);
        #1;
        checkOutput();
    endtask

    task automatic modelStep(input string nm, input logic r, input logic [15:0] d,
                             input logic ld, input logic ic, input logic cl, input logic rt);
        exp_t e;
        if (r) begin
            mPc = 16'h0000; mStack.delete(); mErr = 1'b0;
        end else if (rt) begin
            if (mStack.size() == 0) begin
`ifdef PC_STACK_CHECK_EN
                mErr = 1'b1;
`else
                mPc = 16'h0000;
`endif
            end else begin
                mPc = mStack.pop_back();
            end
        end else if (cl) begin
            if (mStack.size() == 8) begin
`ifdef PC_STACK_CHECK_EN
                mErr = 1'b1;
`else
                void'(mStack.pop_front());
                mStack.push_back(16'(mPc + 16'd1));
                mPc = d;
`endif
            end else begin
                mStack.push_back(16'(mPc + 16'd1));
                mPc = d;
            end
        end else if (ld) begin
            mPc = d;
        end else if (ic) begin
            mPc = 16'(mPc + 16'd1);
        end
        e.name = nm; e.eOut = mPc; e.eCnt = 4'(mStack.size()); e.eErr = mErr;
        applyStimulus(r, d, ld, ic, cl, rt, e);
    endtask

    initial begin
        exp_t e;
        reset = 1'b1; in = '0; load = 1'b0; inc = 1'b0; call = 1'b0; ret = 1'b0;
        mPc = '0; mErr = 1'b0;

        //            name         rst din      ld ic cl rt  out      cnt
        vecs.push_back(mk("reset",   1, 16'h0000, 0, 0, 0, 0, 16'h0000, 0));
        vecs.push_back(mk("inc1",    0, 16'h0000, 0, 1, 0, 0, 16'h0001, 0));
        vecs.push_back(mk("inc2",    0, 16'h0000, 0, 1, 0, 0, 16'h0002, 0));
        vecs.push_back(mk("inc3",    0, 16'h0000, 0, 1, 0, 0, 16'h0003, 0));
        vecs.push_back(mk("ldFFFF",  0, 16'hFFFF, 1, 0, 0, 0, 16'hFFFF, 0));
        vecs.push_back(mk("incWrap", 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0));
        vecs.push_back(mk("ldOvInc", 0, 16'h1234, 1, 1, 0, 0, 16'h1234, 0));
        vecs.push_back(mk("ld0010",  0, 16'h0010, 1, 0, 0, 0, 16'h0010, 0));
        vecs.push_back(mk("call200", 0, 16'h0200, 0, 0, 1, 0, 16'h0200, 1));
        vecs.push_back(mk("inc201",  0, 16'h0000, 0, 1, 0, 0, 16'h0201, 1));
        vecs.push_back(mk("inc202",  0, 16'h0000, 0, 1, 0, 0, 16'h0202, 1));
        vecs.push_back(mk("ret011",  0, 16'h0000, 0, 0, 0, 1, 16'h0011, 0));
        vecs.push_back(mk("ld0100",  0, 16'h0100, 1, 0, 0, 0, 16'h0100, 0));
        vecs.push_back(mk("nest1",   0, 16'h0300, 0, 0, 1, 0, 16'h0300, 1));
        vecs.push_back(mk("nest2",   0, 16'h0500, 0, 0, 1, 0, 16'h0500, 2));
        vecs.push_back(mk("nest3",   0, 16'h0700, 0, 0, 1, 0, 16'h0700, 3));
        vecs.push_back(mk("unnest3", 0, 16'h0000, 0, 0, 0, 1, 16'h0501, 2));
        vecs.push_back(mk("unnest2", 0, 16'h0000, 0, 0, 0, 1, 16'h0301, 1));
        vecs.push_back(mk("unnest1", 0, 16'h0000, 0, 0, 0, 1, 16'h0101, 0));
        vecs.push_back(mk("ld0040",  0, 16'h0040, 1, 0, 0, 0, 16'h0040, 0));
        vecs.push_back(mk("call800", 0, 16'h0800, 0, 0, 1, 0, 16'h0800, 1));
        vecs.push_back(mk("callRet", 0, 16'h0900, 0, 0, 1, 1, 16'h0041, 0));
        vecs.push_back(mk("callA00", 0, 16'h0A00, 0, 0, 1, 0, 16'h0A00, 1));
        vecs.push_back(mk("rstCall", 1, 16'h0B00, 0, 0, 1, 0, 16'h0000, 0));
        vecs.push_back(mk("callLd",  0, 16'h0C00, 1, 0, 1, 0, 16'h0C00, 1));
        vecs.push_back(mk("ret001",  0, 16'h0000, 1, 0, 0, 1, 16'h0001, 0));

        foreach (vecs[i]) begin
            e.name = vecs[i].name; e.eOut = vecs[i].eOut; e.eCnt = vecs[i].eCnt; e.eErr = 1'b0;
            applyStimulus(vecs[i].rst, vecs[i].din, vecs[i].ld, vecs[i].ic,
                          vecs[i].cl, vecs[i].rt, e);
        end

        // Overflow then underflow: DEPTH+1 calls followed by DEPTH+1 returns.
        modelStep("ovRst", 1, 16'h0000, 0, 0, 0, 0);
        modelStep("ovLd",  0, 16'h1000, 1, 0, 0, 0);
        for (int k = 0; k < 9; k++) begin
            modelStep($sformatf("ovCall%0d", k), 0, 16'(16'h2000 + k * 16), 0, 0, 1, 0);
        end
        for (int k = 0; k < 9; k++) begin
            modelStep($sformatf("ovRet%0d", k), 0, 16'h0000, 0, 0, 0, 1);
        end
        modelStep("errInc",  0, 16'h0000, 0, 1, 0, 0);
        modelStep("errLd",   0, 16'h3333, 1, 0, 0, 0);
        modelStep("errRst",  1, 16'h0000, 0, 0, 0, 0);

        // Return on an empty stack from a non-zero PC.
        modelStep("emInc",   0, 16'h0000, 0, 1, 0, 0);
        modelStep("emRet",   0, 16'h0000, 0, 0, 0, 1);
        modelStep("emCall",  0, 16'h4000, 0, 0, 1, 0);
        modelStep("emRet2",  0, 16'h0000, 0, 0, 0, 1);

        reset = 1'b0; load = 1'b0; inc = 1'b0; call = 1'b0; ret = 1'b0;
        if (expQ.size() != 0) begin
            checkCount++;
            $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", expQ.size());
        end
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
